// File: rtl/regfile_wb_sched_pkg.sv
// Shared widths, FSM encoding, requester IDs and write-back payload for the
// register-array write-port scheduler.
package regfile_wb_sched_pkg;

    localparam int unsigned WB_W  = 16;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned NREG  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    typedef struct packed {
        logic [SEL_W-1:0] dest;
        logic [WB_W-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Write-back requester handshakes plus the register-array write port.
interface regfile_wb_sched_if;
    import regfile_wb_sched_pkg::*;

    logic             alu_valid;
    logic             alu_ready;
    logic [SEL_W-1:0] alu_dest;
    logic [WB_W-1:0]  alu_data;
    logic             mem_valid;
    logic             mem_ready;
    logic [SEL_W-1:0] mem_dest;
    logic [WB_W-1:0]  mem_data;
    logic [WB_W-1:0]  WB_DataIn;
    logic [SEL_W-1:0] WB_RegSel;
    logic             L_R0;
    logic             L_RN;

    modport master (
        output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
        input  alu_ready, mem_ready, WB_DataIn, WB_RegSel, L_R0, L_RN
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
        output alu_ready, mem_ready, WB_DataIn, WB_RegSel, L_R0, L_RN
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// In-flight destination scoreboard; a set and a clear on the same index in
// one cycle leave the bit set because the newer instruction is still pending.
module regfile_scoreboard
    import regfile_wb_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_i,
    input  logic [SEL_W-1:0] set_idx_i,
    input  logic             clr_i,
    input  logic [SEL_W-1:0] clr_idx_i,
    input  logic             flush_i,
    input  logic [SEL_W-1:0] rd_sel_i,
    output logic [NREG-1:0]  pending_o,
    output logic             hazard_c_o
);

    logic [NREG-1:0] pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_i)   pending_d[clr_idx_i] = 1'b0;
        if (set_i)   pending_d[set_idx_i] = 1'b1;
        if (flush_i) pending_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    assign pending_o  = pending_q;
    assign hazard_c_o = pending_q[rd_sel_i];

endmodule

// File: rtl/regfile_wb_sched.sv
// Round-robin scheduler for the shared register-array write port, with RAW/WAW
// scoreboard and the drain-then-clear sequence for whole-array clears.
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    regfile_wb_sched_if.slave wb,
    input  logic              iss_valid,
    input  logic [SEL_W-1:0]  iss_dest,
    output logic              iss_stall,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic              rd_hazard,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    state_e           state_q, state_d;
    req_e             rr_q, rr_d;
    logic [WB_W-1:0]  wb_data_q, wb_data_d;
    logic [SEL_W-1:0] wb_sel_q, wb_sel_d;
    logic             l_r0_q, l_r0_d;
    logic             l_rn_q, l_rn_d;
    logic             grant_alu_c, grant_mem_c;
    wb_req_t          win_c;
    logic [NREG-1:0]  pending;

    // Arbitration, clear sequencing and next-cycle write-port contents
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_alu_c = 1'b0;
        grant_mem_c = 1'b0;
        wb_data_d   = wb_data_q;
        wb_sel_d    = wb_sel_q;
        l_r0_d      = 1'b0;
        l_rn_d      = 1'b0;
        win_c       = '{dest: wb.alu_dest, data: wb.alu_data};

        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_DRAIN;
                end else if (wb.alu_valid && wb.mem_valid) begin
                    grant_alu_c = (rr_q == REQ_ALU);
                    grant_mem_c = (rr_q == REQ_MEM);
                    rr_d        = (rr_q == REQ_ALU) ? REQ_MEM : REQ_ALU;
                end else begin
                    grant_alu_c = wb.alu_valid;
                    grant_mem_c = wb.mem_valid;
                end
            end
            ST_DRAIN: begin
                if (pending == '0) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                l_r0_d  = 1'b1;
                l_rn_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_mem_c) win_c = '{dest: wb.mem_dest, data: wb.mem_data};

        if (grant_alu_c || grant_mem_c) begin
            wb_data_d = win_c.data;
            if (win_c.dest == '0) begin
                l_r0_d = 1'b1;
            end else begin
                l_rn_d   = 1'b1;
                wb_sel_d = win_c.dest;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_q      <= REQ_ALU;
            wb_data_q <= '0;
            wb_sel_q  <= '0;
            l_r0_q    <= 1'b0;
            l_rn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            wb_data_q <= wb_data_d;
            wb_sel_q  <= wb_sel_d;
            l_r0_q    <= l_r0_d;
            l_rn_q    <= l_rn_d;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_i      (iss_valid && !iss_stall),
        .set_idx_i  (iss_dest),
        .clr_i      (grant_alu_c || grant_mem_c),
        .clr_idx_i  (win_c.dest),
        .flush_i    (state_q == ST_CLEAR),
        .rd_sel_i   (rd_sel),
        .pending_o  (pending),
        .hazard_c_o (rd_hazard)
    );

    assign iss_stall    = (state_q != ST_IDLE) || pending[iss_dest];
    assign clr_busy     = (state_q != ST_IDLE);
    assign clr_done     = (state_q == ST_CLEAR);
    assign wb.alu_ready = grant_alu_c;
    assign wb.mem_ready = grant_mem_c;
    assign wb.WB_DataIn = wb_data_q;
    assign wb.WB_RegSel = wb_sel_q;
    assign wb.L_R0      = l_r0_q;
    assign wb.L_RN      = l_rn_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed plus random bench for regfile_wb_sched: a behavioural model queues
// expected strobes and a negedge monitor compares every DUT output.
module tb_regfile_wb_sched;
    import regfile_wb_sched_pkg::*;

    localparam int M_IDLE  = 0;
    localparam int M_DRAIN = 1;
    localparam int M_CLEAR = 2;

    typedef struct {
        int due;
        bit r0;
        bit rn;
    } wr_t;

    typedef struct {
        bit          av;
        logic [2:0]  ad;
        logic [15:0] adat;
        bit          mv;
        logic [2:0]  md;
        logic [15:0] mdat;
        bit          iv;
        logic [2:0]  id;
        logic [2:0]  rs;
        bit          cr;
        bit          r;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       iss_valid;
    logic [2:0] iss_dest;
    logic       iss_stall;
    logic [2:0] rd_sel;
    logic       rd_hazard;
    logic       clr_req;
    logic       clr_busy;
    logic       clr_done;

    regfile_wb_sched_if wbif ();

    regfile_wb_sched dut (
        .clk       (clk),
        .rst       (rst),
        .wb        (wbif),
        .iss_valid (iss_valid),
        .iss_dest  (iss_dest),
        .iss_stall (iss_stall),
        .rd_sel    (rd_sel),
        .rd_hazard (rd_hazard),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: current state (m_*) and state after the next edge (nx_*)
    bit          m_pend[8], nx_pend[8];
    int          m_mode, nx_mode;
    bit          m_ptr_mem, nx_ptr_mem;
    logic [15:0] m_data, nx_data;
    logic [2:0]  m_sel, nx_sel;
    bit          exp_ar, exp_mr, exp_stall, exp_haz, exp_busy, exp_done;
    wr_t         q[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < 8; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic commit();
        m_pend    = nx_pend;
        m_mode    = nx_mode;
        m_ptr_mem = nx_ptr_mem;
        m_data    = nx_data;
        m_sel     = nx_sel;
    endtask

    task automatic predict();
        bit          ga, gm;
        logic [2:0]  d;
        logic [15:0] dat;
        ga = 1'b0;
        gm = 1'b0;
        exp_busy  = (m_mode != M_IDLE);
        exp_done  = (m_mode == M_CLEAR);
        exp_stall = (m_mode != M_IDLE) || m_pend[iss_dest];
        exp_haz   = m_pend[rd_sel];
        nx_pend    = m_pend;
        nx_mode    = m_mode;
        nx_ptr_mem = m_ptr_mem;
        nx_data    = m_data;
        nx_sel     = m_sel;
        if (m_mode == M_IDLE && !clr_req) begin
            if (wbif.alu_valid && wbif.mem_valid) begin
                ga = !m_ptr_mem;
                gm = m_ptr_mem;
                nx_ptr_mem = !m_ptr_mem;
            end else begin
                ga = wbif.alu_valid;
                gm = wbif.mem_valid;
            end
        end
        exp_ar = ga;
        exp_mr = gm;
        if (ga || gm) begin
            d   = ga ? wbif.alu_dest : wbif.mem_dest;
            dat = ga ? wbif.alu_data : wbif.mem_data;
            nx_pend[d] = 1'b0;
            nx_data    = dat;
            if (d != 3'd0) nx_sel = d;
            if (!rst) q.push_back('{due: cyc + 1, r0: (d == 3'd0), rn: (d != 3'd0)});
        end
        if (iss_valid && !exp_stall) nx_pend[iss_dest] = 1'b1;
        case (m_mode)
            M_IDLE:  if (clr_req) nx_mode = M_DRAIN;
            M_DRAIN: if (!any_pending()) nx_mode = M_CLEAR;
            default: begin
                nx_mode = M_IDLE;
                for (int i = 0; i < 8; i++) nx_pend[i] = 1'b0;
                if (!rst) q.push_back('{due: cyc + 1, r0: 1'b1, rn: 1'b1});
            end
        endcase
        if (rst) begin
            nx_mode    = M_IDLE;
            nx_ptr_mem = 1'b0;
            nx_data    = '0;
            nx_sel     = '0;
            for (int i = 0; i < 8; i++) nx_pend[i] = 1'b0;
        end
    endtask

    function automatic stim_t idle_s();
        stim_t s;
        s.av = 0; s.ad = 0; s.adat = 0;
        s.mv = 0; s.md = 0; s.mdat = 0;
        s.iv = 0; s.id = 0; s.rs = 0;
        s.cr = 0; s.r = 0;
        return s;
    endfunction

    task automatic tick(input stim_t s);
        @(posedge clk);
        #1;
        commit();
        wbif.alu_valid = s.av; wbif.alu_dest = s.ad; wbif.alu_data = s.adat;
        wbif.mem_valid = s.mv; wbif.mem_dest = s.md; wbif.mem_data = s.mdat;
        iss_valid = s.iv; iss_dest = s.id; rd_sel = s.rs;
        clr_req = s.cr; rst = s.r;
        predict();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(idle_s());
    endtask

    // Monitor: compares every output each cycle, strobes against the queue
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                chk("alu_ready", 32'(wbif.alu_ready), 32'(exp_ar));
                chk("mem_ready", 32'(wbif.mem_ready), 32'(exp_mr));
                chk("iss_stall", 32'(iss_stall), 32'(exp_stall));
                chk("rd_hazard", 32'(rd_hazard), 32'(exp_haz));
                chk("clr_busy",  32'(clr_busy),  32'(exp_busy));
                chk("clr_done",  32'(clr_done),  32'(exp_done));
                chk("WB_DataIn", 32'(wbif.WB_DataIn), 32'(m_data));
                chk("WB_RegSel", 32'(wbif.WB_RegSel), 32'(m_sel));
                if (wbif.L_R0 || wbif.L_RN) begin
                    if (q.size() == 0) begin
                        chk("unexpected_strobe", 32'({wbif.L_R0, wbif.L_RN}), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("strobe_cycle", 32'(cyc), 32'(e.due));
                        chk("L_R0", 32'(wbif.L_R0), 32'(e.r0));
                        chk("L_RN", 32'(wbif.L_RN), 32'(e.rn));
                    end
                end else if (q.size() > 0 && q[0].due <= cyc) begin
                    e = q.pop_front();
                    chk("missing_strobe", 32'({wbif.L_R0, wbif.L_RN}), 32'({e.r0, e.rn}));
                end
            end
        end
    end

    initial begin
        stim_t s;
        wbif.alu_valid = 0; wbif.alu_dest = 0; wbif.alu_data = 0;
        wbif.mem_valid = 0; wbif.mem_dest = 0; wbif.mem_data = 0;
        iss_valid = 0; iss_dest = 0; rd_sel = 0; clr_req = 0; rst = 1;
        m_mode = M_IDLE; m_ptr_mem = 0; m_data = 0; m_sel = 0;
        for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
        predict();

        s = idle_s(); s.r = 1; tick(s); tick(s);
        idle(2);

        // Single ALU write to R5
        s = idle_s(); s.av = 1; s.ad = 3'd5; s.adat = 16'h1234; tick(s);
        idle(2);

        // Both requesters on three consecutive cycles
        for (int k = 0; k < 3; k++) begin
            s = idle_s(); s.av = 1; s.ad = 3'd2; s.adat = 16'hA000 + 16'(k);
            s.mv = 1; s.md = 3'd3; s.mdat = 16'hB000 + 16'(k);
            tick(s);
        end
        idle(2);

        // WAW stall, RAW hazard, released by a memory write-back
        s = idle_s(); s.iv = 1; s.id = 3'd4; tick(s);
        s = idle_s(); s.iv = 1; s.id = 3'd4; s.rs = 3'd4; tick(s);
        s = idle_s(); s.rs = 3'd4; s.mv = 1; s.md = 3'd4; s.mdat = 16'h4444; tick(s);
        s = idle_s(); s.iv = 1; s.id = 3'd4; s.rs = 3'd4; tick(s);
        s = idle_s(); s.rs = 3'd4; s.av = 1; s.ad = 3'd4; s.adat = 16'h0404; tick(s);
        idle(2);

        // R0 routing
        s = idle_s(); s.av = 1; s.ad = 3'd0; s.adat = 16'hBEEF; tick(s);
        idle(2);

        // Clear blocked by pending R6, released by reset, then a clean clear
        s = idle_s(); s.iv = 1; s.id = 3'd6; tick(s);
        s = idle_s(); s.cr = 1; s.av = 1; s.ad = 3'd1; s.adat = 16'h1111; tick(s);
        for (int k = 0; k < 5; k++) begin
            s = idle_s(); s.av = 1; s.ad = 3'd6; s.mv = 1; s.md = 3'd6; s.cr = 1;
            s.iv = 1; s.id = 3'd2; s.rs = 3'd6; tick(s);
        end
        s = idle_s(); s.r = 1; tick(s);
        idle(1);
        s = idle_s(); s.cr = 1; tick(s);
        idle(4);

        // Reset while in CLEAR, and reset during a grant
        s = idle_s(); s.cr = 1; tick(s);
        idle(1);
        s = idle_s(); s.r = 1; tick(s);
        idle(2);
        s = idle_s(); s.av = 1; s.ad = 3'd3; s.adat = 16'h3333; tick(s);
        s = idle_s(); s.av = 1; s.ad = 3'd7; s.adat = 16'h7777; s.r = 1; tick(s);
        idle(2);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            s.av   = 1'($urandom_range(0, 1));
            s.ad   = 3'($urandom_range(0, 7));
            s.adat = 16'($urandom);
            s.mv   = 1'($urandom_range(0, 1));
            s.md   = 3'($urandom_range(0, 7));
            s.mdat = 16'($urandom);
            s.iv   = 1'($urandom_range(0, 1));
            s.id   = 3'($urandom_range(0, 7));
            s.rs   = 3'($urandom_range(0, 7));
            s.cr   = ($urandom_range(0, 29) == 0);
            s.r    = ($urandom_range(0, 59) == 0);
            tick(s);
        end
        idle(4);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
